fp_mul_arbiter: RTL

Shares one combinational `fp_multiplier` (IEEE-754 single precision, P = A × B) among `NUM_REQ` requesters. Each requester uses a valid/ready handshake, and the arbiter runs one operation at a time. Operands and the product are held in registers, so the multiplier's long combinational path sits between two flops. The arbiter instantiates the multiplier internally and sits between the FP-using clients and the multiplier.

---
 rtl/fp_mul_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one registered-operand IEEE-754 single-precision multiplier among NUM_REQ requesters.
// Optional build macro FP_MUL_ARB_RR_EN selects round-robin arbitration; the default build uses fixed priority.
`default_nettype none

module fp_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic               sign;
    logic [7:0]         ea, eb, ea_eff, eb_eff;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0]        sa, sb;
    logic [47:0]        prod, norm;
    logic [5:0]         lzc, sh;
    logic signed [11:0] exp_n;
    logic [95:0]        shifted;
    logic [23:0]        mant;
    logic               guard, sticky, round_up;
    logic [7:0]         exp_base;
    logic [30:0]        mag;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign a_zero = (ea == 8'h00) && (a[22:0] == 23'd0);
    assign b_zero = (eb == 8'h00) && (b[22:0] == 23'd0);
    assign a_inf  = (ea == 8'hff) && (a[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hff) && (b[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hff) && (a[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hff) && (b[22:0] != 23'd0);
    assign ea_eff = (ea == 8'h00) ? 8'd1 : ea;
    assign eb_eff = (eb == 8'h00) ? 8'd1 : eb;
    assign sa     = {ea != 8'h00, a[22:0]};
    assign sb     = {eb != 8'h00, b[22:0]};
    assign prod   = {24'd0, sa} * {24'd0, sb};

    always_comb begin
        lzc = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) lzc = 6'(47 - i);
        end
    end

    // Biased exponent of the product once its leading one sits at bit 47.
    assign norm  = prod << lzc;
    assign exp_n = $signed({4'd0, ea_eff}) + $signed({4'd0, eb_eff}) - 12'sd126
                 - $signed({6'd0, lzc});

    always_comb begin
        if (exp_n > 12'sd0)        sh = 6'd0;
        else if (exp_n < -12'sd46) sh = 6'd48;
        else                       sh = 6'(12'sd1 - exp_n);
    end

    assign shifted  = {norm, 48'd0} >> sh;
    assign mant     = shifted[95:72];
    assign guard    = shifted[71];
    assign sticky   = |shifted[70:0];
    assign round_up = guard & (sticky | mant[0]);
    assign exp_base = (exp_n > 12'sd0) ? 8'(exp_n - 12'sd1) : 8'd0;
    // Hidden bit and rounding carry propagate straight into the exponent field.
    assign mag      = {exp_base, 23'd0} + {7'd0, mant} + {30'd0, round_up};

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) p = 32'h7fc0_0000;
        else if (a_inf || b_inf)                                      p = {sign, 8'hff, 23'd0};
        else if (a_zero || b_zero)                                    p = {sign, 31'd0};
        else if (exp_n >= 12'sd255)                                   p = {sign, 8'hff, 23'd0};
        else                                                          p = {sign, mag};
    end
endmodule

module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_p,
    input  logic                  rsp_ready,
    output logic                  busy,
    output logic [15:0]           op_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [31:0]     a_q, b_q, p_q, mul_p;
    logic [ID_W-1:0] id_q, grant_idx;
    logic            grant_any;
    logic [15:0]     op_count_q;
`ifdef FP_MUL_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;
`endif

    fp_multiplier u_mul (.a(a_q), .b(b_q), .p(mul_p));

    // Descending scan so the requester closest to the search start wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef FP_MUL_ARB_RR_EN
            if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
`else
            if (req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(k);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_any) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_any && !rst) req_ready = NUM_REQ'(1) << grant_idx;
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            id_q       <= '0;
            op_count_q <= '0;
`ifdef FP_MUL_ARB_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            if (state_q == S_IDLE && grant_any) begin
                a_q  <= req_a[grant_idx*32 +: 32];
                b_q  <= req_b[grant_idx*32 +: 32];
                id_q <= grant_idx;
            end
            if (state_q == S_EXEC) p_q <= mul_p;
            if (state_q == S_RESP && rsp_ready) begin
                op_count_q <= op_count_q + 16'd1;
`ifdef FP_MUL_ARB_RR_EN
                ptr_q      <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
`endif
            end
        end
    end

    assign rsp_id   = id_q;
    assign rsp_p    = p_q;
    assign op_count = op_count_q;
endmodule

`default_nettype wire
